// File: rtl/xinyi_trace_pkg.sv
// Shared types for the writeback trace path: the buffered trace entry and default FIFO depth.
package xinyi_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_entry_t;

  localparam int unsigned TRACE_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/wb_trace_fifo.sv
// Two-write/one-read trace FIFO: storage, wrapping pointers and occupancy level.
// wr_cnt entries (0..2) are written in order wr_data0 then wr_data1; caller guarantees space.
module wb_trace_fifo
  import xinyi_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   wr_cnt,
  input  trace_entry_t wr_data0,
  input  trace_entry_t wr_data1,
  input  logic         pop,
  output trace_entry_t head,
  output logic [LW-1:0] level
);

  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] wr_ptr_p1;

  always_comb begin
    wr_ptr_p1 = wr_ptr_q + AW'(1);
    mem_d     = mem_q;
    if (wr_cnt != 2'd0) mem_d[wr_ptr_q]  = wr_data0;
    if (wr_cnt == 2'd2) mem_d[wr_ptr_p1] = wr_data1;
    // Pointer width equals log2(DEPTH), so wrap-around is the natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(wr_cnt);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(wr_cnt) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/wb_trace_serializer.sv
// Merges the two writeback slots into one in-order debug_wb_* trace lane via a small FIFO.
// Optional retired-write counter port enabled by defining WB_TRACE_PERF_CNT_EN.
module wb_trace_serializer
  import xinyi_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH_DEFAULT,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wb0_en,
  input  logic [4:0]    wb0_rd,
  input  logic [31:0]   wb0_wdata,
  input  logic [31:0]   wb0_pc,
  input  logic          wb1_en,
  input  logic [4:0]    wb1_rd,
  input  logic [31:0]   wb1_wdata,
  input  logic [31:0]   wb1_pc,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [31:0]   debug_wb_rf_wdata,
  output logic [LW-1:0] trace_level,
  output logic          trace_overflow
`ifdef WB_TRACE_PERF_CNT_EN
  ,
  output logic [31:0]   retired_cnt
`endif
);

  logic          q0, q1, pop, drop;
  logic [1:0]    n_req, n_acc;
  logic [LW-1:0] level, space;
  trace_entry_t  e0, e1, wr_data0, head;
  trace_entry_t  out_q, out_d;
  logic          vld_q, vld_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    q0    = wb0_en && (wb0_rd != 5'd0);
    q1    = wb1_en && (wb1_rd != 5'd0);
    e0    = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    e1    = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};
    pop   = (level != '0);
    space = LW'(DEPTH) - level + LW'(pop);
    n_req = 2'(q0) + 2'(q1);
    // Slot 1 fills the first free entry when slot 0 is filtered; the tail is dropped first.
    wr_data0 = q0 ? e0 : e1;
    if (LW'(n_req) <= space) begin
      n_acc = n_req;
      drop  = 1'b0;
    end else begin
      n_acc = space[1:0];
      drop  = 1'b1;
    end
    ovf_d = ovf_q | drop;
    vld_d = pop;
    out_d = pop ? head : '0;
  end

  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .wr_cnt   (n_acc),
    .wr_data0 (wr_data0),
    .wr_data1 (e1),
    .pop      (pop),
    .head     (head),
    .level    (level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign debug_wb_pc       = out_q.pc;
  assign debug_wb_rf_wen   = {4{vld_q}};
  assign debug_wb_rf_wnum  = out_q.rd;
  assign debug_wb_rf_wdata = out_q.wdata;
  assign trace_level       = level;
  assign trace_overflow    = ovf_q;

`ifdef WB_TRACE_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'(wb0_en) + 32'(wb1_en);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Self-checking bench for wb_trace_serializer: vector table plus hand-written overflow/reset/wrap sequences.
module tb_wb_trace_serializer;
  import xinyi_trace_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb0_en, wb1_en;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_wdata, wb0_pc, wb1_wdata, wb1_pc;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [3:0]  trace_level;
  logic        trace_overflow;
`ifdef WB_TRACE_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  wb_trace_serializer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb0_en            (wb0_en),
    .wb0_rd            (wb0_rd),
    .wb0_wdata         (wb0_wdata),
    .wb0_pc            (wb0_pc),
    .wb1_en            (wb1_en),
    .wb1_rd            (wb1_rd),
    .wb1_wdata         (wb1_wdata),
    .wb1_pc            (wb1_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_level       (trace_level),
    .trace_overflow    (trace_overflow)
`ifdef WB_TRACE_PERF_CNT_EN
    ,
    .retired_cnt       (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  trace_entry_t sb[$];
  trace_entry_t exp_out;
  logic         exp_vld;
  logic         exp_ovf;
  logic [31:0]  exp_cnt;

  typedef struct {
    logic       en0;
    logic [4:0] rd0;
    logic       en1;
    logic [4:0] rd1;
    logic [3:0] exp_level;
    logic [4:0] exp_wnum;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pc",    debug_wb_pc,       exp_vld ? exp_out.pc : 32'h0);
    chk("wen",   32'(debug_wb_rf_wen), exp_vld ? 32'hF : 32'h0);
    chk("wnum",  32'(debug_wb_rf_wnum), exp_vld ? 32'(exp_out.rd) : 32'h0);
    chk("wdata", debug_wb_rf_wdata, exp_vld ? exp_out.wdata : 32'h0);
    chk("level", 32'(trace_level),  32'(sb.size()));
    chk("ovf",   32'(trace_overflow), 32'(exp_ovf));
`ifdef WB_TRACE_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, exp_cnt);
`endif
  endtask

  // Called just after a falling edge: drives one cycle, advances the model, checks after the edge.
  task automatic drive_cycle(input logic e0, input logic [4:0] r0, input logic [31:0] p0, input logic [31:0] d0,
                             input logic e1, input logic [4:0] r1, input logic [31:0] p1, input logic [31:0] d1);
    int space;
    wb0_en = e0; wb0_rd = r0; wb0_pc = p0; wb0_wdata = d0;
    wb1_en = e1; wb1_rd = r1; wb1_pc = p1; wb1_wdata = d1;
    exp_vld = (sb.size() != 0);
    if (exp_vld) exp_out = sb.pop_front();
    space = DEPTH - sb.size();
    if (e0 && r0 != 5'd0) begin
      if (space > 0) begin sb.push_back('{pc: p0, rd: r0, wdata: d0}); space--; end
      else exp_ovf = 1'b1;
    end
    if (e1 && r1 != 5'd0) begin
      if (space > 0) begin sb.push_back('{pc: p1, rd: r1, wdata: d1}); space--; end
      else exp_ovf = 1'b1;
    end
    exp_cnt = exp_cnt + 32'(e0) + 32'(e1);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    drive_cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] pc0;
    resetn = 1'b0;
    wb0_en = 0; wb0_rd = 0; wb0_pc = 0; wb0_wdata = 0;
    wb1_en = 0; wb1_rd = 0; wb1_pc = 0; wb1_wdata = 0;
    exp_vld = 0; exp_ovf = 0; exp_cnt = 0; exp_out = '0;

    //            en0 rd0 en1 rd1 level wnum
    tbl[0]  = '{1, 2, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 2};
    tbl[2]  = '{0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 3, 1, 4, 2, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 3};
    tbl[5]  = '{0, 0, 0, 0, 0, 4};
    tbl[6]  = '{0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 5, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 5};
    tbl[9]  = '{0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 7, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      pc0 = 32'hbfc00000 + 32'(i) * 8;
      drive_cycle(tbl[i].en0, tbl[i].rd0, pc0, 32'h1234 + 32'(i) * 2,
                  tbl[i].en1, tbl[i].rd1, pc0 + 4, 32'hA000 + 32'(i));
      chk("tbl_level", 32'(trace_level), 32'(tbl[i].exp_level));
      chk("tbl_wnum", 32'(debug_wb_rf_wnum), 32'(tbl[i].exp_wnum));
    end

    // Overflow: both slots qualify for 8 cycles; drop first happens on the 8th.
    for (int k = 1; k <= 8; k++) begin
      pc0 = 32'h8000_0000 + 32'(k) * 8;
      drive_cycle(1'b1, 5'(k), pc0, 32'h100 + 32'(k), 1'b1, 5'(k + 10), pc0 + 4, 32'h200 + 32'(k));
      if (k == 7) chk("ovf_before", 32'(trace_overflow), 32'h0);
      if (k == 8) begin
        chk("ovf_rise", 32'(trace_overflow), 32'h1);
        chk("ovf_level", 32'(trace_level), 32'd8);
      end
    end
    for (int t = 0; t < 20 && sb.size() != 0; t++) idle();
    chk("drain_empty", 32'(sb.size()), 32'h0);
    idle();
    chk("ovf_sticky", 32'(trace_overflow), 32'h1);

    // Reset mid-stream with level 5.
    for (int k = 0; k < 4; k++)
      drive_cycle(1'b1, 5'd9, 32'h9000_0000 + 32'(k) * 8, 32'(k), 1'b1, 5'd10, 32'h9000_0004 + 32'(k) * 8, 32'(k));
    chk("pre_reset_level", 32'(trace_level), 32'd5);
    #2 resetn = 1'b0;
    #1;
    chk("rst_pc", debug_wb_pc, 32'h0);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("rst_wnum", 32'(debug_wb_rf_wnum), 32'h0);
    chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rst_level", 32'(trace_level), 32'h0);
    chk("rst_ovf", 32'(trace_overflow), 32'h0);
    sb.delete();
    exp_ovf = 0; exp_cnt = 0;
    wb0_en = 0; wb1_en = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) idle();

    // Wrap-around: 20 single pushes through slot 1 only.
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'((i % 31) + 1), 32'hC000_0000 + 32'(i) * 4, 32'h5A00 + 32'(i));
    for (int t = 0; t < 5 && sb.size() != 0; t++) idle();
    chk("wrap_drained", 32'(sb.size()), 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
